// File: rtl/slow_tick_gen.sv
// ----------------------------------------------------------------------------
// slow_tick_gen
// Produces the single-cycle slowena strobe that advances enable-gated counters
// (e.g. Slow_Decade) from the fast clock. A programmable prescaler sets the
// strobe period to div+1 clk cycles. Three operating modes:
//   01 free-run : strobe indefinitely until stop
//   10 burst    : issue burst_len strobes, then pulse done
//   11 step     : one strobe per 4-phase step_req/step_ack handshake
//
// Optional feature macro: SLOW_TICK_PAUSE_EN
//   When defined, an extra input "pause" freezes the prescaler and suppresses
//   slowena while in RUN/BURST. The default build has no pause port.
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   reset      in   1      synchronous, active-low
//   pause      in   1      (SLOW_TICK_PAUSE_EN only) freeze prescaler
//   div        in   DIV_W  prescale value, latched when start is accepted
//   mode       in   2      00 idle, 01 free-run, 10 burst, 11 step
//   burst_len  in   CNT_W  strobes per burst, latched when start is accepted
//   start      in   1      launch free-run/burst (sampled in IDLE only)
//   stop       in   1      abort RUN/BURST; wins over start in IDLE
//   step_req   in   1      step request (mode 11)
//   step_ack   out  1      step acknowledge
//   slowena    out  1      one-cycle enable strobe
//   busy       out  1      high in RUN, BURST or STEP_ACK
//   done       out  1      one-cycle pulse after a burst completes normally
//   tick_cnt   out  CNT_W  strobes issued since last start (wraps)
// All outputs are registered.
// ----------------------------------------------------------------------------
module slow_tick_gen #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SLOW_TICK_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             start,
   input  logic             stop,
   input  logic             step_req,
   output logic             step_ack,
   output logic             slowena,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] tick_cnt
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_BURST    = 2'd2,
      S_STEP_ACK = 2'd3
   } state_t;

   localparam logic [1:0] MODE_RUN   = 2'b01;
   localparam logic [1:0] MODE_BURST = 2'b10;
   localparam logic [1:0] MODE_STEP  = 2'b11;

   state_t           r_state;
   logic [DIV_W-1:0] r_presc;
   logic [DIV_W-1:0] r_div;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_tick_cnt;
   logic             r_slowena;
   logic             r_step_ack;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_next;
   logic [DIV_W-1:0] w_presc_next;
   logic [DIV_W-1:0] w_div_next;
   logic [CNT_W-1:0] w_len_next;
   logic [CNT_W-1:0] w_tick_cnt_next;
   logic             w_slowena_next;
   logic             w_step_ack_next;
   logic             w_done_next;
   logic             w_paused;
   logic             w_wrap;

`ifdef SLOW_TICK_PAUSE_EN
   assign w_paused = pause;
`else
   assign w_paused = 1'b0;
`endif

   // Prescaler has reached the latched terminal value this cycle.
   assign w_wrap = (r_presc == r_div);

   always_comb begin
      w_state_next    = r_state;
      w_presc_next    = r_presc;
      w_div_next      = r_div;
      w_len_next      = r_len;
      w_tick_cnt_next = r_tick_cnt;
      w_slowena_next  = 1'b0;
      w_step_ack_next = 1'b0;
      w_done_next     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start && !stop && (mode == MODE_RUN || mode == MODE_BURST)) begin
               w_state_next    = (mode == MODE_RUN) ? S_RUN : S_BURST;
               w_presc_next    = '0;
               w_div_next      = div;
               w_len_next      = burst_len;
               w_tick_cnt_next = '0;
            end else if (step_req && mode == MODE_STEP) begin
               // Strobe on entry only; a held request cannot re-trigger
               // because STEP_ACK is left only once step_req is seen low.
               w_state_next    = S_STEP_ACK;
               w_slowena_next  = 1'b1;
               w_step_ack_next = 1'b1;
               w_tick_cnt_next = r_tick_cnt + 1'b1;
            end
         end

         S_RUN, S_BURST: begin
            if (stop) begin
               w_state_next = S_IDLE;
            end else if (r_state == S_BURST && r_tick_cnt == r_len) begin
               // Completion is checked before any new strobe so a burst
               // never overshoots, including burst_len == 0.
               w_done_next  = 1'b1;
               w_state_next = S_IDLE;
            end else if (!w_paused) begin
               if (w_wrap) begin
                  w_slowena_next  = 1'b1;
                  w_presc_next    = '0;
                  w_tick_cnt_next = r_tick_cnt + 1'b1;
               end else begin
                  w_presc_next = r_presc + 1'b1;
               end
            end
         end

         S_STEP_ACK: begin
            if (step_req) begin
               w_step_ack_next = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end

         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_presc    <= '0;
         r_div      <= '0;
         r_len      <= '0;
         r_tick_cnt <= '0;
         r_slowena  <= 1'b0;
         r_step_ack <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_presc    <= w_presc_next;
         r_div      <= w_div_next;
         r_len      <= w_len_next;
         r_tick_cnt <= w_tick_cnt_next;
         r_slowena  <= w_slowena_next;
         r_step_ack <= w_step_ack_next;
         r_busy     <= (w_state_next != S_IDLE);
         r_done     <= w_done_next;
      end
   end

   assign slowena  = r_slowena;
   assign step_ack = r_step_ack;
   assign busy     = r_busy;
   assign done     = r_done;
   assign tick_cnt = r_tick_cnt;

endmodule
